// File: rtl/gray_fifo_pkg.sv
// Shared constants and the binary-to-Gray helper for the Gray-pointer FIFO controller.
package gray_fifo_pkg;

  localparam int ADDR_WIDTH_DEFAULT = 4;

  // Wide enough for any pointer; callers zero-extend in and keep the low bits.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray_ptr.sv
// One FIFO pointer kept as a binary and a Gray register.
// Both registers advance together, so they always describe the same position.
module gray_ptr
  import gray_fifo_pkg::*;
#(
  parameter int WIDTH = ADDR_WIDTH_DEFAULT + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin_next,
  output logic [WIDTH-1:0] gray_next
);

  logic [31:0] gray_wide;
  logic        unused_gray_bits;

  assign bin_next  = inc ? bin + WIDTH'(1) : bin;
  assign gray_wide = bin2gray(32'(bin_next));
  assign gray_next = gray_wide[WIDTH-1:0];

  assign unused_gray_bits = ^gray_wide[31:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      bin  <= '0;
      gray <= '0;
    end else begin
      bin  <= bin_next;
      gray <= gray_next;
    end
  end

endmodule

// File: rtl/gray_fifo_ctrl.sv
// FIFO controller with Gray-coded pointers, registered full/empty/count flags,
// and one-cycle overflow/underflow pulses for rejected requests.
module gray_fifo_ctrl
  import gray_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = ADDR_WIDTH + 1;

  logic          wr_acc;
  logic          rd_acc;
  logic [PW-1:0] wr_bin;
  logic [PW-1:0] rd_bin;
  logic [PW-1:0] wr_bin_next;
  logic [PW-1:0] rd_bin_next;
  logic [PW-1:0] wr_gray_next;
  logic [PW-1:0] rd_gray_next;
  logic [PW-1:0] rd_gray_wrapped;
  logic          unused_ptr_msbs;

  // Reset blocks acceptance so nothing reaches storage during a reset cycle.
  assign wr_acc = wr_en & ~full & ~rst;
  assign rd_acc = rd_en & ~empty & ~rst;

  assign mem_we    = wr_acc;
  assign mem_waddr = wr_bin[ADDR_WIDTH-1:0];
  assign mem_raddr = rd_bin[ADDR_WIDTH-1:0];

  assign unused_ptr_msbs = wr_bin[ADDR_WIDTH] ^ rd_bin[ADDR_WIDTH];

  gray_ptr #(.WIDTH(PW)) u_wr_ptr (
    .clk       (clk),
    .rst       (rst),
    .inc       (wr_acc),
    .bin       (wr_bin),
    .gray      (wr_ptr_gray),
    .bin_next  (wr_bin_next),
    .gray_next (wr_gray_next)
  );

  gray_ptr #(.WIDTH(PW)) u_rd_ptr (
    .clk       (clk),
    .rst       (rst),
    .inc       (rd_acc),
    .bin       (rd_bin),
    .gray      (rd_ptr_gray),
    .bin_next  (rd_bin_next),
    .gray_next (rd_gray_next)
  );

  // Writer a full lap ahead of the reader shows up in Gray as the top two bits inverted.
  assign rd_gray_wrapped = {~rd_gray_next[PW-1:PW-2], rd_gray_next[PW-3:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      full      <= 1'b0;
      empty     <= 1'b1;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      empty     <= (wr_gray_next == rd_gray_next);
      full      <= (wr_gray_next == rd_gray_wrapped);
      count     <= wr_bin_next - rd_bin_next;
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;
    end
  end

endmodule

// File: tb/tb_gray_fifo_ctrl.sv
// Self-checking bench for gray_fifo_ctrl (ADDR_WIDTH=4) against an occupancy-counter model.
module tb_gray_fifo_ctrl;
  import gray_fifo_pkg::*;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic       rd_en;
  logic       mem_we;
  logic [3:0] mem_waddr;
  logic [3:0] mem_raddr;
  logic [4:0] wr_ptr_gray;
  logic [4:0] rd_ptr_gray;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int n_cmp;
  int n_fail;

  // Model: total accepted writes/reads since reset; everything else derives from these.
  int         wr_cnt;
  int         rd_cnt;
  logic       exp_we;
  logic       exp_ovf;
  logic       exp_unf;
  logic [3:0] exp_waddr;
  logic [3:0] exp_raddr;
  logic       obs_we;
  logic [3:0] obs_waddr;
  logic [3:0] obs_raddr;

  gray_fifo_ctrl #(.ADDR_WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .mem_we      (mem_we),
    .mem_waddr   (mem_waddr),
    .mem_raddr   (mem_raddr),
    .wr_ptr_gray (wr_ptr_gray),
    .rd_ptr_gray (rd_ptr_gray),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] model_gray(input int cnt);
    logic [31:0] w;
    w = bin2gray(32'(cnt % 32));
    return w[4:0];
  endfunction

  function automatic logic [4:0] model_count();
    return 5'(wr_cnt - rd_cnt);
  endfunction

  // Drive one cycle, sample the combinational strobe before the edge, update the model.
  task automatic cycle(input logic w, input logic r, input logic rs);
    int occ;
    rst   = rs;
    wr_en = w;
    rd_en = r;
    #1;
    obs_we    = mem_we;
    obs_waddr = mem_waddr;
    obs_raddr = mem_raddr;
    occ       = wr_cnt - rd_cnt;
    exp_waddr = 4'(wr_cnt % 16);
    exp_raddr = 4'(rd_cnt % 16);
    if (rs) begin
      exp_we  = 1'b0;
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
      wr_cnt  = 0;
      rd_cnt  = 0;
    end else begin
      exp_we  = w && (occ < 16);
      exp_ovf = w && (occ == 16);
      exp_unf = r && (occ == 0);
      if (w && occ < 16) wr_cnt++;
      if (r && occ > 0) rd_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b0, 1'b0, 1'b1);
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_empty got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_full got %b want 0", full); end
    n_cmp++; if (count !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (wr_ptr_gray !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_wgray got %b want 00000", wr_ptr_gray); end
    n_cmp++; if (rd_ptr_gray !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_rgray got %b want 00000", rd_ptr_gray); end
    n_cmp++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pulses got %b%b want 00", overflow, underflow); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      n_cmp++; if (obs_we !== 1'b1 || obs_waddr !== 4'(i)) begin n_fail++; $display("[TB] FAIL fill_write got we=%b addr=%0d want we=1 addr=%0d", obs_we, obs_waddr, i); end
    end
    n_cmp++; if (full !== 1'b1 || empty !== 1'b0) begin n_fail++; $display("[TB] FAIL fill_flags got full=%b empty=%b want 1/0", full, empty); end
    n_cmp++; if (count !== 5'd16) begin n_fail++; $display("[TB] FAIL fill_count got %0d want 16", count); end
    n_cmp++; if (wr_ptr_gray !== 5'b11000) begin n_fail++; $display("[TB] FAIL fill_wgray got %b want 11000", wr_ptr_gray); end
  endtask

  task automatic test_overflow();
    cycle(1'b1, 1'b0, 1'b0);
    n_cmp++; if (obs_we !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_we got %b want 0", obs_we); end
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_pulse got %b want 1", overflow); end
    n_cmp++; if (wr_ptr_gray !== 5'b11000 || full !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_hold got gray=%b full=%b want 11000/1", wr_ptr_gray, full); end
    cycle(1'b0, 1'b0, 1'b0);
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_single got %b want 0", overflow); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, 1'b0);
      n_cmp++; if (obs_raddr !== 4'(i) || obs_we !== 1'b0) begin n_fail++; $display("[TB] FAIL drain_read got addr=%0d we=%b want addr=%0d we=0", obs_raddr, obs_we, i); end
    end
    n_cmp++; if (empty !== 1'b1 || count !== 5'd0) begin n_fail++; $display("[TB] FAIL drain_state got empty=%b count=%0d want 1/0", empty, count); end
    n_cmp++; if (rd_ptr_gray !== 5'b11000) begin n_fail++; $display("[TB] FAIL drain_rgray got %b want 11000", rd_ptr_gray); end
    cycle(1'b0, 1'b1, 1'b0);
    n_cmp++; if (underflow !== 1'b1 || rd_ptr_gray !== 5'b11000) begin n_fail++; $display("[TB] FAIL unf_pulse got unf=%b gray=%b want 1/11000", underflow, rd_ptr_gray); end
    cycle(1'b0, 1'b0, 1'b0);
    n_cmp++; if (underflow !== 1'b0) begin n_fail++; $display("[TB] FAIL unf_single got %b want 0", underflow); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] prev_w;
    logic [4:0] prev_r;
    int         pw;
    int         pr;
    prev_w = wr_ptr_gray;
    prev_r = rd_ptr_gray;
    for (int i = 0; i < 40; i++) begin
      pw = wr_cnt;
      pr = rd_cnt;
      cycle(1'b1, 1'b1, 1'b0);
      n_cmp++; if (count > 5'd1 || count !== model_count()) begin n_fail++; $display("[TB] FAIL b2b_count cyc=%0d got %0d want %0d", i, count, model_count()); end
      n_cmp++; if (underflow !== (i == 0) || overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_pulses cyc=%0d got unf=%b ovf=%b want unf=%b ovf=0", i, underflow, overflow, (i == 0)); end
      n_cmp++; if ($countones(wr_ptr_gray ^ prev_w) != ((wr_cnt != pw) ? 1 : 0) || wr_ptr_gray !== model_gray(wr_cnt)) begin n_fail++; $display("[TB] FAIL b2b_wgray cyc=%0d got %b prev %b want %b", i, wr_ptr_gray, prev_w, model_gray(wr_cnt)); end
      n_cmp++; if ($countones(rd_ptr_gray ^ prev_r) != ((rd_cnt != pr) ? 1 : 0) || rd_ptr_gray !== model_gray(rd_cnt)) begin n_fail++; $display("[TB] FAIL b2b_rgray cyc=%0d got %b prev %b want %b", i, rd_ptr_gray, prev_r, model_gray(rd_cnt)); end
      prev_w = wr_ptr_gray;
      prev_r = rd_ptr_gray;
    end
  endtask

  task automatic test_full_both();
    for (int i = 0; i < 15; i++) cycle(1'b1, 1'b0, 1'b0);
    n_cmp++; if (full !== 1'b1 || count !== 5'd16) begin n_fail++; $display("[TB] FAIL fb_setup got full=%b count=%0d want 1/16", full, count); end
    cycle(1'b1, 1'b1, 1'b0);
    n_cmp++; if (obs_we !== 1'b0 || overflow !== 1'b1) begin n_fail++; $display("[TB] FAIL fb_reject got we=%b ovf=%b want 0/1", obs_we, overflow); end
    n_cmp++; if (full !== 1'b0 || count !== 5'd15) begin n_fail++; $display("[TB] FAIL fb_read got full=%b count=%0d want 0/15", full, count); end
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    n_cmp++; if (obs_we !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_we got %b want 0", obs_we); end
    n_cmp++; if (wr_ptr_gray !== 5'd0 || rd_ptr_gray !== 5'd0) begin n_fail++; $display("[TB] FAIL rstmid_ptrs got %b/%b want 0/0", wr_ptr_gray, rd_ptr_gray); end
    n_cmp++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_flags got count=%0d empty=%b full=%b want 0/1/0", count, empty, full); end
    cycle(1'b0, 1'b0, 1'b0);
    n_cmp++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_pulses got %b%b want 00", overflow, underflow); end
  endtask

  task automatic test_random();
    logic w;
    logic r;
    logic rs;
    int   occ;
    for (int i = 0; i < 400; i++) begin
      // Alternate write-heavy and read-heavy phases so both full and empty are visited.
      if ((i / 50) % 2 == 0) begin
        w = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 3) == 0);
      end else begin
        w = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 3) != 0);
      end
      rs = ($urandom_range(0, 63) == 0);
      cycle(w, r, rs);
      occ = wr_cnt - rd_cnt;
      n_cmp++; if (obs_we !== exp_we || (exp_we && obs_waddr !== exp_waddr)) begin n_fail++; $display("[TB] FAIL rnd_write cyc=%0d got we=%b addr=%0d want we=%b addr=%0d", i, obs_we, obs_waddr, exp_we, exp_waddr); end
      n_cmp++; if (obs_raddr !== exp_raddr) begin n_fail++; $display("[TB] FAIL rnd_raddr cyc=%0d got %0d want %0d", i, obs_raddr, exp_raddr); end
      n_cmp++; if (count !== model_count() || full !== (occ == 16) || empty !== (occ == 0)) begin n_fail++; $display("[TB] FAIL rnd_state cyc=%0d got count=%0d full=%b empty=%b want count=%0d", i, count, full, empty, occ); end
      n_cmp++; if (wr_ptr_gray !== model_gray(wr_cnt) || rd_ptr_gray !== model_gray(rd_cnt)) begin n_fail++; $display("[TB] FAIL rnd_gray cyc=%0d got %b/%b want %b/%b", i, wr_ptr_gray, rd_ptr_gray, model_gray(wr_cnt), model_gray(rd_cnt)); end
      n_cmp++; if (overflow !== exp_ovf || underflow !== exp_unf) begin n_fail++; $display("[TB] FAIL rnd_pulses cyc=%0d got ovf=%b unf=%b want %b/%b", i, overflow, underflow, exp_ovf, exp_unf); end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    wr_cnt = 0;
    rd_cnt = 0;
    rst    = 1'b1;
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_back_to_back();
    test_full_both();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
